timer_multi_channel: RTL
========================

Name: timer_multi_channel

Overview:
- NUM_CH independent up/down timer channels sharing one programmable prescaler.
- Each channel runs periodic (auto-reload) or one-shot between per-channel min/max bounds.
- Each channel emits a wrap event pulse and holds a sticky interrupt flag.
- Sits in the timer subsystem as the generalised successor of the single-channel counter; feeds the interrupt aggregator.

Parameters:
- NUM_CH, 4: number of channels.
- CNT_W, 16: counter width per channel.
- PRESC_W, 8: prescaler divider width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- presc_div  in  PRESC_W  tick period minus one; 0 gives a tick every cycle.
- ch_en  in  NUM_CH  per-channel count enable; gates ticks only.
- ch_up  in  NUM_CH  1 = count up, 0 = count down.
- ch_oneshot  in  NUM_CH  1 = stop after first wrap.
- ch_start  in  NUM_CH  pulse: load start value and enter RUN.
- ch_stop  in  NUM_CH  pulse: return to IDLE, value held.
- ch_min  in  NUM_CH*CNT_W  packed lower bounds, channel 0 in LSBs.
- ch_max  in  NUM_CH*CNT_W  packed upper bounds.
- irq_clr  in  NUM_CH  clears sticky irq.
- ch_value  out  NUM_CH*CNT_W  packed current counts.
- ch_busy  out  NUM_CH  1 when channel is in RUN.
- wrap_evt  out  NUM_CH  one-cycle pulse on wrap.
- irq  out  NUM_CH  sticky wrap flag.

Behaviour:
- Reset: all outputs 0; prescaler count 0; every channel in IDLE.
- Prescaler:
  - Counts 0..presc_div while any ch_en bit is 1; asserts tick in the cycle count==presc_div, then returns to 0.
  - Holds at 0 when all ch_en bits are 0.
  - A presc_div change takes effect at the next count comparison.
- Channel FSM states: IDLE, RUN, DONE.
  - ch_start (any state): value <= ch_min if ch_up else ch_max; state -> RUN; registered, visible next cycle. A tick in the start cycle is ignored.
  - ch_stop: state -> IDLE, value held. If ch_start and ch_stop are asserted together, ch_start wins.
  - RUN, tick & ch_en, up: if value >= max, wrap; else value+1.
  - RUN, tick & ch_en, down: if value <= min, wrap; else value-1.
  - Periodic wrap: value <= min (up) or max (down); wrap_evt=1 in the cycle the reload is visible.
  - One-shot wrap: value holds at the boundary; state -> DONE; wrap_evt pulses once. DONE exits only via start or stop.
- ch_up is sampled on every tick, so a direction change applies from the next tick.
- Misconfiguration min > max is defined behaviour: every tick wraps (up: value=min; down: value=max). No arithmetic overflow, because comparisons use >= and <=.
- min == max: every tick wraps; value is constant.
- irq[i] is set by wrap_evt[i] and cleared by irq_clr[i]; if both occur in the same cycle, set wins.
- ch_busy = (state == RUN).
- Reset asserted mid-count aborts immediately to the reset values.

Optional Feature:
- TIMER_CHAIN_EN defined: channel k>0 with ch_en[k]=1 takes its tick from wrap_evt[k-1] instead of the prescaler, cascading into a NUM_CH*CNT_W-bit counter. Channel 0 always uses the prescaler.
- TIMER_CHAIN_EN undefined: all channels use the prescaler tick; no chaining logic is present.

Decomposition:
- Package timer_pkg:
  - ch_state_e enum (IDLE, RUN, DONE).
  - Default width constants.
  - Function clog2 helper.
- Sub-module timer_channel: one channel FSM, counter, wrap and irq logic. Instantiated NUM_CH times by generate.
- The prescaler and the chaining mux stay in the top level.

Test Plan:
- presc_div=0, ch0 up, min=2, max=5, start: values 2,3,4,5,2 on successive cycles; wrap_evt once per 4 ticks; irq sticky until irq_clr.
- presc_div=3, ch1 down, min=0, max=3, one-shot: decrements every 4 cycles to 0; wrap → value 0, DONE, ch_busy=0, single wrap_evt.
- ch_start and ch_stop asserted together mid-run: channel restarts at min; ch_busy=1. irq_clr and wrap in the same cycle: irq stays 1.
- min=10, max=4, up: every tick value=10 with wrap_evt. Toggle ch_up mid-run: next tick moves in the new direction.
- Assert rst while value=7 and irq=1: all outputs 0 immediately (asynchronous); channel in IDLE after release.
- TIMER_CHAIN_EN, CNT_W=4, ch0 and ch1 up with min=0, max=15: ch1 increments once per 16 ch0 ticks; ch1 wraps after 256 ticks.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and defaults for the multi-channel timer.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } ch_state_e;

  localparam int unsigned DefNumCh  = 4;
  localparam int unsigned DefCntW   = 16;
  localparam int unsigned DefPrescW = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, bounded up/down counter, wrap pulse and sticky irq.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cnt_min,
  input  logic [CNT_W-1:0] cnt_max,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] value,
  output logic             busy,
  output logic             wrap_evt,
  output logic             irq
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  logic             irq_q, irq_d;

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    wrap_d  = 1'b0;
    // irq follows the visible wrap pulse; a coincident clear loses
    irq_d   = wrap_q | (irq_q & ~irq_clr);
    if (start) begin
      value_d = up ? cnt_min : cnt_max;
      state_d = StRun;
    end else if (stop) begin
      state_d = StIdle;
    end else if (state_q == StRun && tick && en) begin
      // >= / <= keep min > max well defined: every tick wraps
      if (up) begin
        if (value_q >= cnt_max) wrap_d = 1'b1;
        else                    value_d = value_q + CNT_W'(1);
      end else begin
        if (value_q <= cnt_min) wrap_d = 1'b1;
        else                    value_d = value_q - CNT_W'(1);
      end
      if (wrap_d) begin
        if (oneshot) state_d = StDone;
        else         value_d = up ? cnt_min : cnt_max;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      value_q <= '0;
      wrap_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      wrap_q  <= wrap_d;
      irq_q   <= irq_d;
    end
  end

  assign value    = value_q;
  assign busy     = (state_q == StRun);
  assign wrap_evt = wrap_q;
  assign irq      = irq_q;

endmodule

// File: rtl/timer_multi_channel.sv
// NUM_CH bounded up/down timers sharing one prescaler.
// Define TIMER_CHAIN_EN to let enabled channel k>0 tick on wrap_evt[k-1] (cascaded counter).
module timer_multi_channel
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH  = DefNumCh,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned PRESC_W = DefPrescW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PRESC_W-1:0]      presc_div,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_up,
  input  logic [NUM_CH-1:0]       ch_oneshot,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_stop,
  input  logic [NUM_CH*CNT_W-1:0] ch_min,
  input  logic [NUM_CH*CNT_W-1:0] ch_max,
  input  logic [NUM_CH-1:0]       irq_clr,
  output logic [NUM_CH*CNT_W-1:0] ch_value,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       wrap_evt,
  output logic [NUM_CH-1:0]       irq
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               presc_tick;

  // Prescaler parks at 0 while no channel is enabled
  always_comb begin
    presc_tick = (|ch_en) && (presc_q == presc_div);
    if (!(|ch_en) || presc_tick) presc_d = '0;
    else                         presc_d = presc_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic ch_tick;

`ifdef TIMER_CHAIN_EN
    if (k == 0) begin : g_src_presc
      assign ch_tick = presc_tick;
    end else begin : g_src_chain
      assign ch_tick = ch_en[k] ? wrap_evt[k-1] : presc_tick;
    end
`else
    assign ch_tick = presc_tick;
`endif

    timer_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .tick     (ch_tick),
      .en       (ch_en[k]),
      .up       (ch_up[k]),
      .oneshot  (ch_oneshot[k]),
      .start    (ch_start[k]),
      .stop     (ch_stop[k]),
      .cnt_min  (ch_min[k*CNT_W +: CNT_W]),
      .cnt_max  (ch_max[k*CNT_W +: CNT_W]),
      .irq_clr  (irq_clr[k]),
      .value    (ch_value[k*CNT_W +: CNT_W]),
      .busy     (ch_busy[k]),
      .wrap_evt (wrap_evt[k]),
      .irq      (irq[k])
    );
  end

endmodule
